// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, frame constants
// and the even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with async active-high reset. count_next_o exposes
// the post-edge occupancy so the parent can register its ready flag.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign data_o       = mem_q[rd_q];
  assign full_o       = (cnt_q == FULL_CNT);
  assign empty_o      = (cnt_q == '0);
  assign count_o      = cnt_q;
  assign count_next_o = cnt_d;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (LSB first) with FIFO front end and CTS flow control
// checked only between frames. Define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT = 645,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          cts_n_in,
  output logic                          tx,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_COUNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ready_q;
  logic          cts_meta_q, cts_sync_q;
  logic          push_s, pop_s, bit_end_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_data_s;
  logic [CW-1:0] count_s, count_next_s;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign push_s = valid_in && ready_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .data_i       (data_in),
    .data_o       (fifo_data_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  assign bit_end_s = (baud_q == BAUD_LAST);

  // tx_d follows the current state, so the line lags the FSM by one clock.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    tx_d    = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) begin
      baud_d = bit_end_s ? '0 : baud_q + 1'b1;
    end else begin
      baud_d = '0;
    end
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifo_empty_s && !cts_sync_q) begin
          pop_s   = 1'b1;
          shift_d = fifo_data_s;
          bit_d   = 3'd0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_data_s);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end_s) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
          state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end_s) state_d = STOP;
        else           state_d = PARITY;
      end
`endif
      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (bit_end_s) state_d = IDLE;
        else           state_d = STOP;
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // State, datapath, CTS synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_q    <= (count_next_s != FULL_CNT);
      cts_meta_q <= cts_n_in;
      cts_sync_q <= cts_meta_q;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign ready_out = ready_q;
  assign count_out = count_s;
  assign busy_out  = (state_q != IDLE) || (count_s != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: pushes expected bytes into a queue; a line
// monitor decodes each frame clock by clock and compares against it.
module tb_uart_tx;

  localparam int B = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       cts_n_in = 1'b1;
  logic       ready_out, tx, busy_out;
  logic [2:0] count_out;

  uart_tx #(.BAUD_COUNT(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .cts_n_in(cts_n_in), .tx(tx),
    .busy_out(busy_out), .count_out(count_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;
  int         last_push_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: on a start bit, compare every clock of the frame with the
  // level implied by the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        logic [7:0]  b;
        logic [10:0] fb;
        logic [7:0]  got;
        int          errs, ones;
        bit          aborted, have;
        mon_busy = 1'b1;
        starts.push_back(cyc);
        have = (exp_q.size() != 0);
        b = have ? exp_q.pop_front() : 8'h00;
        ones = 0;
        fb = 11'h7FF;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
          fb[i+1] = (b >> i) & 8'd1;
          ones += (b >> i) & 8'd1;
        end
        if (NBITS == 11) fb[9] = ones % 2;
        errs = 0;
        got = 8'h00;
        aborted = 1'b0;
        for (int t = 0; t < NBITS * B; t++) begin
          if (t > 0) @(negedge clk);
          if (!mon_en) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== fb[t / B]) errs++;
          if ((t % B) == B / 2 && (t / B) >= 1 && (t / B) <= 8)
            got[(t / B) - 1] = tx;
        end
        if (!aborted) begin
          check("frame_expected", int'(have), 1);
          check("frame_waveform_errors", errs, 0);
          check("frame_byte", int'(got), int'(b));
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!ready_out && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready_out) begin
      check("push_ready_timeout", int'(ready_out), 1);
      return;
    end
    data_in  = b;
    valid_in = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || mon_busy || busy_out || tx !== 1'b1) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check(name, int'(w >= 5000), 0);
  endtask

  task automatic wait_starts(input int n);
    int w = 0;
    while (starts.size() < n && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("wait_starts_timeout", int'(w >= 2000), 0);
  endtask

  initial begin
    int pcyc, w;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(ready_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_count", int'(count_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", int'(ready_out), 1);
    mon_en = 1'b1;

    // single byte, latency and busy drop
    cts_n_in = 1'b0;
    repeat (3) @(negedge clk);
    starts.delete();
    push(8'hA5);
    pcyc = last_push_cyc;
    wait_idle("single_idle_timeout");
    check("single_frames", starts.size(), 1);
    if (starts.size() > 0) check("single_latency", starts[0] - pcyc, 2);
    check("single_busy_after", int'(busy_out), 0);

    // fill with CTS blocked
    cts_n_in = 1'b1;
    repeat (3) @(negedge clk);
    starts.delete();
    for (int i = 1; i <= 4; i++) push(8'(i));
    @(negedge clk);
    check("fill_count", int'(count_out), 4);
    check("fill_ready", int'(ready_out), 0);
    data_in  = 8'h05;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("full_push_count", int'(count_out), 4);
    check("full_push_tx", int'(tx), 1);
    check("blocked_frames", starts.size(), 0);

    // release CTS: four back-to-back frames
    cts_n_in = 1'b0;
    w = 0;
    while (!ready_out && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_after_pop", int'(ready_out), 1);
    wait_idle("fill_idle_timeout");
    check("fill_frames", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++)
      check("fill_spacing", starts[i] - starts[i-1], NBITS * B + 1);

    // CTS raised during second frame's data
    starts.delete();
    push(8'h3C);
    push(8'hC3);
    push(8'h5A);
    wait_starts(2);
    repeat (12) @(negedge clk);
    cts_n_in = 1'b1;
    w = 0;
    while ((exp_q.size() != 1 || mon_busy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (60) @(negedge clk);
    check("hold_frames", starts.size(), 2);
    check("hold_count", int'(count_out), 1);
    check("hold_tx", int'(tx), 1);
    if (starts.size() >= 2) check("hold_b2_spacing", starts[1] - starts[0], NBITS * B + 1);
    cts_n_in = 1'b0;
    wait_idle("hold_idle_timeout");
    check("hold_resume_frames", starts.size(), 3);

    // random bytes with random gaps
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
      push(8'($urandom));
    end
    wait_idle("random_idle_timeout");

`ifdef UART_TX_PARITY_EN
    starts.delete();
    push(8'h07);
    push(8'h03);
    wait_idle("parity_idle_timeout");
    check("parity_frames", starts.size(), 2);
    if (starts.size() >= 2) check("parity_spacing", starts[1] - starts[0], 11 * B + 1);
`endif

    // reset in the middle of a frame
    starts.delete();
    push(8'h00);
    push(8'h81);
    wait_starts(1);
    repeat (10) @(negedge clk);
    check("pre_rst_tx_low", int'(tx), 0);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_count", int'(count_out), 0);
    check("midrst_ready", int'(ready_out), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", int'(ready_out), 1);
    check("post_rst_busy", int'(busy_out), 0);
    check("post_rst_tx", int'(tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
